// File: rtl/fetch.sv
// fetch: instruction fetch stage of the in-order RV32 pipeline (IF/ID producer).
//
// Owns the fetch PC, issues in-order word requests to instruction memory under
// a credit limit of BUF_DEPTH (in-flight requests plus buffered words), buffers
// returned words with their PCs, and presents one registered pc_o/inst_o pair
// per cycle to decode. Decode redirects (pcsel != 0) flush the buffer and mark
// every in-flight response for discard. StallFetch_i holds IF/ID and the
// buffer head; redirects seen while stalled are ignored.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - a kept response arriving while the buffer is empty and IF/ID
//               is advancing loads straight into IF/ID (one cycle less latency)
//   undefined - every response passes through the buffer
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   StallFetch_i          hold IF/ID register and buffer head
//   pcsel, branch_tar     redirect request/target from decode
//   imem_req_o/addr_o     request valid / word address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response valid / data
//   pc_o, inst_o          IF/ID register
//   inst_valid_o          IF/ID holds a real instruction
module fetch #(
  parameter int                  WIDTH     = 32,
  parameter int                  ADDR_LEN  = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                  BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallFetch_i,
  input  logic [1:0]          pcsel,
  input  logic [ADDR_LEN-1:0] branch_tar,
  output logic                imem_req_o,
  output logic [ADDR_LEN-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [WIDTH-1:0]    imem_rdata_i,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [WIDTH-1:0]    inst_o,
  output logic                inst_valid_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [WIDTH-1:0] NOP     = WIDTH'(32'h0000_0013);
  localparam logic [IW-1:0]    LAST    = IW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [ADDR_LEN-1:0] pc;
    logic [WIDTH-1:0]    inst;
  } entry_t;

  logic [ADDR_LEN-1:0] fetch_pc;
  logic [CW-1:0]       outstanding, drop_cnt, buf_cnt;

  // PC of every granted request, consumed in order as responses return
  logic [ADDR_LEN-1:0] tag_mem [BUF_DEPTH];
  logic [IW-1:0]       tag_wr, tag_rd;

  entry_t              ibuf_mem [BUF_DEPTH];
  logic [IW-1:0]       ibuf_wr, ibuf_rd;

  logic   redir, fire, keep, advance, push, pop, byp;
  entry_t rsp;
  logic   unused_tar_lsb;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign redir       = (pcsel != 2'b00) && !StallFetch_i;
  assign imem_req_o  = !reset && !redir && ((outstanding + buf_cnt) < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o && imem_gnt_i;
  assign keep        = imem_rvalid_i && (drop_cnt == '0);
  assign advance     = !StallFetch_i && !redir;
  assign rsp         = '{pc: tag_mem[tag_rd], inst: imem_rdata_i};

`ifdef FETCH_BYPASS_EN
  assign byp = keep && advance && (buf_cnt == '0);
`else
  assign byp = 1'b0;
`endif

  // a same-cycle kept response is lost to the flush on redirect
  assign push = keep && !redir && !byp;
  assign pop  = advance && (buf_cnt != '0);

  // target is word aligned, low bits carry no meaning here
  assign unused_tar_lsb = ^branch_tar[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_cnt     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      ibuf_wr     <= '0;
      ibuf_rd     <= '0;
    end else begin
      if (redir)     fetch_pc <= {branch_tar[ADDR_LEN-1:2], 2'b00};
      else if (fire) fetch_pc <= fetch_pc + ADDR_LEN'(4);

      outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid_i);

      // after a redirect every request still in flight is wrong-path; one
      // returning this edge (kept or dropped) is already out of flight
      if (redir)
        drop_cnt <= outstanding - CW'(imem_rvalid_i);
      else if (imem_rvalid_i && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;

      if (fire)          tag_wr <= nxt(tag_wr);
      if (imem_rvalid_i) tag_rd <= nxt(tag_rd);

      if (redir) begin
        buf_cnt <= '0;
        ibuf_wr <= '0;
        ibuf_rd <= '0;
      end else begin
        buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
        if (push) ibuf_wr <= nxt(ibuf_wr);
        if (pop)  ibuf_rd <= nxt(ibuf_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) tag_mem[tag_wr]   <= fetch_pc;
    if (push) ibuf_mem[ibuf_wr] <= rsp;
  end

  // IF/ID register; pc_o keeps its value whenever a NOP is loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_o         <= '0;
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
    end else if (redir) begin
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
    end else if (advance) begin
      if (pop) begin
        pc_o         <= ibuf_mem[ibuf_rd].pc;
        inst_o       <= ibuf_mem[ibuf_rd].inst;
        inst_valid_o <= 1'b1;
      end else if (byp) begin
        pc_o         <= rsp.pc;
        inst_o       <= rsp.inst;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule
